// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Shares a single 64-bit memory port between the instruction-fetch side
//   (32-bit, read-only) and the data side (64-bit load/store) of the core.
//   Requests are serialised through a four-state FSM
//   (IDLE -> SERVE_I | SERVE_D -> RESP -> IDLE). While an access is in
//   flight, the memory-side signals come only from registers latched at grant
//   time, so they stay stable until mem_ready. Each access completes with a
//   one-cycle ready pulse to the side that was served, and the read data is
//   registered.
//
//   The D side has priority. A starvation counter tracks consecutive D grants
//   made while a fetch is waiting. Once STARVE_MAX such grants have happened,
//   the next grant goes to the I side.
//
// Ports:
//   clk        clock, everything on the rising edge
//   rst        synchronous, active-high reset (aborts any access in flight)
//   i_req      fetch request, held high until i_ready
//   i_addr     fetch word address
//   i_rdata    fetched 32-bit word, valid while i_ready=1
//   i_ready    one-cycle fetch completion pulse
//   d_req      data request, held high until d_ready
//   d_wen      1 = store, 0 = load
//   d_addr     data word address
//   d_wdata    store data
//   d_rdata    load data, valid while d_ready=1
//   d_ready    one-cycle data completion pulse
//   mem_cen    memory access enable (high only in SERVE_I / SERVE_D)
//   mem_wen    memory write enable (never high for a fetch)
//   mem_addr   memory word address
//   mem_wdata  memory write data
//   mem_rdata  memory read data, valid with mem_ready
//   mem_ready  memory completion, may take any number of cycles
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W     = 30,
  parameter int DATA_W     = 64,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_ready,

  input  logic              d_req,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,

  output logic              mem_cen,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  // The counter must be able to hold the value STARVE_MAX itself.
  localparam int              CNT_W      = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t             state;
  state_t             state_next;

  logic               grant_i;
  logic               grant_d;
  logic               in_serve;
  logic               i_forced;

  logic [ADDR_W-1:0]  addr_q;
  logic               wen_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  rdata_q;
  logic               served_d;
  logic [CNT_W-1:0]   starve_cnt;

  // Both serving states drive the memory. Factoring this out keeps the
  // capture and output logic from repeating the state comparison.
  assign in_serve = (state == SERVE_I) || (state == SERVE_D);

  // The fetch side wins over a pending data request only when the D side has
  // already been granted STARVE_MAX times in a row while the fetch waited.
  assign i_forced = i_req && (starve_cnt == STARVE_LIM);

  // State register. Reset also cancels an access in flight: the FSM goes back
  // to IDLE, so mem_cen drops on the next cycle and no ready pulse is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and grant decode. Requests are looked at only in IDLE. Once
  // an access starts, the FSM waits only for mem_ready. In RESP the FSM
  // always returns to IDLE, so a request that is still held high is
  // arbitrated again as a fresh request.
  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && !i_forced) begin
          grant_d    = 1'b1;
          state_next = SERVE_D;
        end else if (i_req) begin
          grant_i    = 1'b1;
          state_next = SERVE_I;
        end
      end
      SERVE_I, SERVE_D: begin
        if (mem_ready) begin
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Request capture at grant time. From here until the access finishes, the
  // memory side sees only these registers, so any change on the request
  // inputs mid-access has no effect. A fetch always latches wen=0.
  // served_d records which side gets the RESP pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      wen_q    <= 1'b0;
      wdata_q  <= '0;
      served_d <= 1'b0;
    end else if (grant_d) begin
      addr_q   <= d_addr;
      wen_q    <= d_wen;
      wdata_q  <= d_wdata;
      served_d <= 1'b1;
    end else if (grant_i) begin
      addr_q   <= i_addr;
      wen_q    <= 1'b0;
      served_d <= 1'b0;
    end
  end

  // Read data is taken from the memory only in the cycle it completes an
  // access. A stray mem_ready in IDLE or RESP is ignored, so the captured
  // word stays stable through the RESP cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (in_serve && mem_ready) begin
      rdata_q <= mem_rdata;
    end
  end

  // Starvation counter:
  //   - counts D grants made while a fetch is pending, saturating at the limit;
  //   - clears on any I grant;
  //   - clears on a D grant when no fetch is waiting, because the streak is
  //     then broken.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (grant_i) begin
      starve_cnt <= '0;
    end else if (grant_d) begin
      if (!i_req) begin
        starve_cnt <= '0;
      end else if (starve_cnt != STARVE_LIM) begin
        starve_cnt <= starve_cnt + CNT_ONE;
      end
    end
  end

  // Output decode:
  //   - mem_cen is high only in the serving states.
  //   - mem_wen needs both a serving state and a latched store, so a fetch
  //     can never write.
  //   - The ready pulse goes only to the side recorded at grant time.
  //   - The latched address LSB selects which half of the 64-bit memory word
  //     a fetch returns.
  always_comb begin
    mem_cen   = in_serve;
    mem_wen   = (state == SERVE_D) && wen_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    i_ready   = (state == RESP) && !served_d;
    d_ready   = (state == RESP) && served_d;
    d_rdata   = rdata_q;
    i_rdata   = addr_q[0] ? rdata_q[32 +: 32] : rdata_q[0 +: 32];
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Purpose:
//   Self-checking bench for mem_port_arbiter. The DUT is built with
//   STARVE_MAX=2 so the fairness pattern is short. Stimulus is driven on the
//   falling clock edge and outputs are sampled on the falling edge, well away
//   from the rising edge the DUT uses.
//
// Checks:
//   - Single accesses come from a table of records. Each record is pushed
//     into a scoreboard queue when its request is driven, and popped when the
//     ready pulse appears.
//   - Arbitration order under contention is checked against a queue of
//     expected grant sides.
//   - A hand-written sequence covers reset in the middle of an access and a
//     stray mem_ready while the arbiter is idle.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int          ADDR_W     = 30;
  localparam int          DATA_W     = 64;
  localparam int          STARVE_MAX = 2;
  localparam logic [29:0] I_ADDR     = 30'h0000_0001;
  localparam logic [29:0] D_ADDR     = 30'h0000_0002;

  typedef struct {
    string        name;
    logic         is_d;
    logic         wen;
    logic [29:0]  addr;
    logic [63:0]  wdata;
    logic [63:0]  rdata;
    int           delay;
    logic [63:0]  exp_rdata;
  } vec_t;

  logic              clk;
  logic              rst;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [31:0]       i_rdata;
  logic              i_ready;
  logic              d_req;
  logic              d_wen;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ready;
  logic              mem_cen;
  logic              mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  int   checks;
  int   failures;
  vec_t exp_q[$];
  bit   grant_q[$];
  vec_t vecs[7];

  mem_port_arbiter #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .STARVE_MAX (STARVE_MAX)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .i_rdata   (i_rdata),
    .i_ready   (i_ready),
    .d_req     (d_req),
    .d_wen     (d_wen),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ready   (d_ready),
    .mem_cen   (mem_cen),
    .mem_wen   (mem_wen),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Builds one table record. The expected read data is written out as a
  // literal in the table, not derived from the DUT.
  function automatic vec_t mkVec(input string name, input logic is_d, input logic wen,
                                 input logic [29:0] addr, input logic [63:0] wdata,
                                 input logic [63:0] rdata, input int delay,
                                 input logic [63:0] exp_rdata);
    vec_t v;
    v.name      = name;
    v.is_d      = is_d;
    v.wen       = wen;
    v.addr      = addr;
    v.wdata     = wdata;
    v.rdata     = rdata;
    v.delay     = delay;
    v.exp_rdata = exp_rdata;
    return v;
  endfunction

  // A single comparison. It bumps the counters and reports any difference.
  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Synchronous reset held for two cycles, released on a falling edge.
  task automatic resetDut();
    rst       = 1'b1;
    i_req     = 1'b0;
    d_req     = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives one table record and acts as the memory model for it:
  //   - The memory answers after v.delay wait cycles.
  //   - While the access is in progress, the request inputs are scrambled, so
  //     the memory-side signals must still show the values captured at grant
  //     time.
  //   - The expected record is popped from the scoreboard when a ready pulse
  //     appears.
  task automatic applyStimulus(input vec_t v);
    int   wait_cnt;
    int   cen_cycles;
    int   latency;
    bit   done;
    bit   hold_bad;
    bit   overlap_bad;
    vec_t e;
    wait_cnt    = 0;
    cen_cycles  = 0;
    latency     = 0;
    done        = 1'b0;
    hold_bad    = 1'b0;
    overlap_bad = 1'b0;
    @(negedge clk);
    mem_ready = 1'b0;
    if (v.is_d) begin
      d_req   = 1'b1;
      d_wen   = v.wen;
      d_addr  = v.addr;
      d_wdata = v.wdata;
    end else begin
      i_req  = 1'b1;
      i_addr = v.addr;
    end
    exp_q.push_back(v);
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if ((i_ready && d_ready) || (mem_cen && (i_ready || d_ready)))
        overlap_bad = 1'b1;
      if (mem_cen) begin
        cen_cycles++;
        if (mem_addr !== v.addr) hold_bad = 1'b1;
        if (mem_wen !== (v.is_d & v.wen)) hold_bad = 1'b1;
        if (v.is_d && v.wen && (mem_wdata !== v.wdata)) hold_bad = 1'b1;
        d_addr  = ~v.addr;
        d_wdata = ~v.wdata;
        d_wen   = ~v.wen;
        i_addr  = ~v.addr;
        if (wait_cnt == v.delay) begin
          mem_ready = 1'b1;
          mem_rdata = v.rdata;
        end else begin
          mem_ready = 1'b0;
          mem_rdata = ~v.rdata;
          wait_cnt++;
        end
      end else begin
        mem_ready = 1'b0;
      end
      if (i_ready || d_ready) begin
        done    = 1'b1;
        latency = c + 1;
        e       = exp_q.pop_front();
        checkOutput({e.name, " i_ready"}, 64'(i_ready), 64'(!e.is_d));
        checkOutput({e.name, " d_ready"}, 64'(d_ready), 64'(e.is_d));
        if (!e.is_d)
          checkOutput({e.name, " i_rdata"}, 64'(i_rdata), e.exp_rdata);
        else if (!e.wen)
          checkOutput({e.name, " d_rdata"}, d_rdata, e.exp_rdata);
        checkOutput({e.name, " cen_cycles"}, 64'(cen_cycles), 64'(e.delay + 1));
        checkOutput({e.name, " latency"}, 64'(latency), 64'(e.delay + 2));
        i_req = 1'b0;
        d_req = 1'b0;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s timeout: got no ready expected ready pulse", v.name);
      exp_q.delete();
      i_req = 1'b0;
      d_req = 1'b0;
    end
    checkOutput({v.name, " held_mem_signals_bad"}, 64'(hold_bad), 64'd0);
    checkOutput({v.name, " overlap_bad"}, 64'(overlap_bad), 64'd0);
    mem_ready = 1'b0;
    @(negedge clk);
    checkOutput({v.name, " ready_after_pulse"}, 64'(i_ready | d_ready), 64'd0);
    checkOutput({v.name, " cen_in_idle"}, 64'(mem_cen), 64'd0);
  endtask

  // Holds i_req and d_req high together, with a memory that answers at once.
  // Each new rise of mem_cen is a grant, and its side is compared with the
  // next entry in grant_q. The side of each ready pulse must match the last
  // grant. Both requests are dropped after the n-th access completes.
  task automatic runGrants(input int n);
    int grants;
    bit last_d;
    bit prev_cen;
    bit exp_side;
    bit finished;
    grants   = 0;
    last_d   = 1'b0;
    finished = 1'b0;
    i_addr   = I_ADDR;
    d_addr   = D_ADDR;
    d_wen    = 1'b0;
    i_req    = 1'b1;
    d_req    = 1'b1;
    prev_cen = mem_cen;
    for (int c = 0; c < 100 && !finished; c++) begin
      @(negedge clk);
      if (mem_cen && !prev_cen) begin
        exp_side = (grant_q.size() > 0) ? grant_q.pop_front() : 1'b0;
        last_d   = (mem_addr == D_ADDR);
        checkOutput($sformatf("grant%0d side_is_d", grants), 64'(last_d), 64'(exp_side));
        checkOutput($sformatf("grant%0d mem_wen", grants), 64'(mem_wen), 64'd0);
        grants++;
      end
      if (i_ready || d_ready) begin
        checkOutput($sformatf("grant%0d ready_is_d", grants), 64'(d_ready), 64'(last_d));
        checkOutput($sformatf("grant%0d both_ready", grants), 64'(i_ready & d_ready), 64'd0);
        if (grants == n) begin
          i_req    = 1'b0;
          d_req    = 1'b0;
          finished = 1'b1;
        end
      end
      prev_cen  = mem_cen;
      mem_ready = mem_cen;
    end
    if (!finished) begin
      checks++;
      failures++;
      $display("[TB] FAIL runGrants timeout: got %0d grants expected %0d", grants, n);
      i_req = 1'b0;
      d_req = 1'b0;
    end
    grant_q.delete();
    mem_ready = 1'b0;
    @(negedge clk);
  endtask

  // Main test sequence.
  initial begin : main
    int  grants;
    bit  prev_cen;
    bit  stray_bad;
    checks    = 0;
    failures  = 0;
    rst       = 1'b1;
    i_req     = 1'b0;
    i_addr    = '0;
    d_req     = 1'b0;
    d_wen     = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;

    vecs[0] = mkVec("ifetch_hi",   1'b0, 1'b0, 30'h0000_0005, 64'h0,
                    64'hAAAABBBB_11112222, 3, 64'h00000000_AAAABBBB);
    vecs[1] = mkVec("dstore",      1'b1, 1'b1, 30'h0000_0010, 64'hDEADBEEF_01234567,
                    64'h0, 0, 64'h0);
    vecs[2] = mkVec("ifetch_lo",   1'b0, 1'b0, 30'h0000_0004, 64'h0,
                    64'h13579BDF_2468ACE0, 0, 64'h00000000_2468ACE0);
    vecs[3] = mkVec("dload_top",   1'b1, 1'b0, 30'h3FFF_FFFF, 64'h0,
                    64'hFEDCBA98_76543210, 2, 64'hFEDCBA98_76543210);
    vecs[4] = mkVec("dload_zero",  1'b1, 1'b0, 30'h0000_0000, 64'h0,
                    64'h0F0F0F0F_F0F0F0F0, 5, 64'h0F0F0F0F_F0F0F0F0);
    vecs[5] = mkVec("ifetch_top",  1'b0, 1'b0, 30'h3FFF_FFFF, 64'h0,
                    64'h89ABCDEF_55AA55AA, 1, 64'h00000000_89ABCDEF);
    vecs[6] = mkVec("dstore_slow", 1'b1, 1'b1, 30'h2AAA_AAAA, 64'h01234567_89ABCDEF,
                    64'h0, 4, 64'h0);

    // Every output must come up as zero out of reset.
    resetDut();
    @(negedge clk);
    checkOutput("reset mem_cen",   64'(mem_cen),   64'd0);
    checkOutput("reset mem_wen",   64'(mem_wen),   64'd0);
    checkOutput("reset mem_addr",  64'(mem_addr),  64'd0);
    checkOutput("reset mem_wdata", mem_wdata,      64'd0);
    checkOutput("reset i_ready",   64'(i_ready),   64'd0);
    checkOutput("reset d_ready",   64'(d_ready),   64'd0);
    checkOutput("reset i_rdata",   64'(i_rdata),   64'd0);
    checkOutput("reset d_rdata",   d_rdata,        64'd0);

    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
    end

    // With continuous contention and a limit of 2, the grant order must be
    // D,D,I,D,D,I.
    resetDut();
    grant_q.push_back(1'b1); grant_q.push_back(1'b1); grant_q.push_back(1'b0);
    grant_q.push_back(1'b1); grant_q.push_back(1'b1); grant_q.push_back(1'b0);
    runGrants(6);

    // The first D grant under contention raises the starvation count to 1,
    // and the second D grant is then stalled. Reset during that stall must
    // cancel the access, drop mem_cen on the next cycle, suppress the ready
    // pulse, and clear the count.
    resetDut();
    i_addr   = I_ADDR;
    d_addr   = D_ADDR;
    d_wen    = 1'b1;
    d_wdata  = 64'hCAFEF00D_12345678;
    i_req    = 1'b1;
    d_req    = 1'b1;
    grants   = 0;
    prev_cen = 1'b0;
    for (int c = 0; c < 60 && grants < 2; c++) begin
      @(negedge clk);
      if (mem_cen && !prev_cen) grants++;
      prev_cen  = mem_cen;
      mem_ready = (grants < 2) ? mem_cen : 1'b0;
    end
    checkOutput("abort grants_seen", 64'(grants), 64'd2);
    checkOutput("abort serving_d_addr", 64'(mem_addr), 64'(D_ADDR));
    checkOutput("abort serving_wen", 64'(mem_wen), 64'd1);
    @(negedge clk);
    checkOutput("abort still_serving", 64'(mem_cen), 64'd1);
    rst   = 1'b1;
    i_req = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
    checkOutput("abort cen_after_rst", 64'(mem_cen), 64'd0);
    checkOutput("abort d_ready_after_rst", 64'(d_ready), 64'd0);
    rst = 1'b0;

    // A stray mem_ready with the arbiter idle and no request pending must
    // not start an access or produce a ready pulse.
    stray_bad = 1'b0;
    mem_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (mem_cen || i_ready || d_ready) stray_bad = 1'b1;
    end
    mem_ready = 1'b0;
    checkOutput("stray_ready_in_idle", 64'(stray_bad), 64'd0);

    // If reset had not cleared the count, the I side would win first here.
    grant_q.push_back(1'b1); grant_q.push_back(1'b1); grant_q.push_back(1'b0);
    runGrants(3);

    // An ordinary fetch after the aborted access must still be served
    // normally.
    applyStimulus(vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
